// File: rtl/axis_arb_pkg.sv
// Shared types, default widths and the round-robin pick function for the
// frame-atomic AXI4-Stream arbiter.
package axis_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam int DEF_NUM_SRC   = 4;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_MAX_BEATS = 256;
   localparam int DEF_CNT_W     = 16;

   // rr_pick works on the widest supported source count; narrower callers zero-extend.
   localparam int MAX_SRC   = 8;
   localparam int IDX_MAX_W = 3;

   // First requester searching upward from ptr+1 modulo n; returns ptr when nobody requests.
   function automatic logic [IDX_MAX_W-1:0] rr_pick(
      input logic [MAX_SRC-1:0]   req,
      input logic [IDX_MAX_W-1:0] ptr,
      input int                   n
   );
      logic [IDX_MAX_W-1:0] pick;
      logic                 found;
      int                   idx;
      pick  = ptr;
      found = 1'b0;
      for (int k = 1; k <= MAX_SRC; k++) begin
         idx = (int'(ptr) + k) % n;
         if ((k <= n) && !found && req[idx[IDX_MAX_W-1:0]]) begin
            pick  = idx[IDX_MAX_W-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_pointer_arbiter.sv
// Combinational round-robin pick over a request vector plus the registered
// priority pointer, which advances to the pick whenever load is strobed.
module rr_pointer_arbiter
   import axis_arb_pkg::*;
#(
   parameter int N     = DEF_NUM_SRC,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic [N-1:0]     req,
   input  logic             load,
   output logic [IDX_W-1:0] pick
);

   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [MAX_SRC-1:0] req_ext;

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = req;
      pick           = IDX_W'(rr_pick(req_ext, IDX_MAX_W'(ptr_q), N));
      ptr_d          = load ? pick : ptr_q;
   end

   // Pointer starts at the last source so that source 0 has priority after reset.
   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) ptr_q <= IDX_W'(N - 1);
      else          ptr_q <= ptr_d;
   end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-atomic round-robin arbiter: one source owns the master port from its
// first beat to tlast, with an optional beat-count watchdog cutting runaway frames.
module axis_frame_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NUM_SRC   = DEF_NUM_SRC,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BEATS = DEF_MAX_BEATS,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [NUM_SRC*DATA_W-1:0]   s_axis_tdata,
   input  logic [NUM_SRC-1:0]          s_axis_tvalid,
   output logic [NUM_SRC-1:0]          s_axis_tready,
   input  logic [NUM_SRC-1:0]          s_axis_tlast,
   input  logic [NUM_SRC-1:0]          s_axis_tuser,
   output logic [DATA_W-1:0]           m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic                        m_axis_tuser,
   output logic [$clog2(NUM_SRC)-1:0]  grant_idx,
   output logic                        busy,
   output logic [CNT_W-1:0]            frame_cnt,
   output logic                        trunc_err
);

   localparam int   IDX_W   = $clog2(NUM_SRC);
   localparam int   BEAT_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam bit   WD_EN   = (MAX_BEATS != 0);
   localparam int   WD_LAST = WD_EN ? MAX_BEATS - 1 : 0;

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic              trunc_q, trunc_d;
   logic              arb_load;
   logic [IDX_W-1:0]  arb_pick;
   logic              wd_hit;
   logic              beat_acc;

   rr_pointer_arbiter #(
      .N     (NUM_SRC),
      .IDX_W (IDX_W)
   ) u_rr (
      .aclk    (aclk),
      .aresetn (aresetn),
      .req     (s_axis_tvalid),
      .load    (arb_load),
      .pick    (arb_pick)
   );

   assign wd_hit = WD_EN && (beat_q == BEAT_W'(WD_LAST));

   // Pass-through from the granted source; everything is quiet while idle.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      s_axis_tready = '0;
      if (state_q == BUSY) begin
         m_axis_tdata           = s_axis_tdata[int'(grant_q)*DATA_W +: DATA_W];
         m_axis_tvalid          = s_axis_tvalid[grant_q];
         m_axis_tlast           = s_axis_tlast[grant_q] | wd_hit;
         m_axis_tuser           = s_axis_tuser[grant_q];
         s_axis_tready[grant_q] = m_axis_tready;
      end
   end

   assign beat_acc = m_axis_tvalid & m_axis_tready;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      beat_d      = beat_q;
      frame_cnt_d = frame_cnt_q;
      trunc_d     = trunc_q;
      arb_load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|s_axis_tvalid) begin
               grant_d  = arb_pick;
               arb_load = 1'b1;
               beat_d   = '0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (beat_acc) begin
               beat_d = beat_q + BEAT_W'(1);
               if (m_axis_tlast) begin
                  frame_cnt_d = frame_cnt_q + CNT_W'(1);
                  state_d     = IDLE;
                  // Only a cut the source did not ask for is an error.
                  if (wd_hit && !s_axis_tlast[grant_q]) trunc_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         beat_q      <= '0;
         frame_cnt_q <= '0;
         trunc_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         beat_q      <= beat_d;
         frame_cnt_q <= frame_cnt_d;
         trunc_q     <= trunc_d;
      end
   end

   assign grant_idx = grant_q;
   assign busy      = (state_q == BUSY);
   assign frame_cnt = frame_cnt_q;
   assign trunc_err = trunc_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Scoreboard bench for axis_frame_arbiter (4 sources, watchdog at 4 beats,
// 4-bit frame counter): expected beats are queued as frames are driven.
module tb_axis_frame_arbiter;

   localparam int NSRC = 4;
   localparam int DW   = 32;
   localparam int MAXB = 4;
   localparam int CW   = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic          user;
   } beat_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic          user;
      logic [1:0]    src;
   } exp_t;

   logic                 aclk    = 1'b0;
   logic                 aresetn = 1'b0;
   logic [NSRC*DW-1:0]   s_axis_tdata  = '0;
   logic [NSRC-1:0]      s_axis_tvalid = '0;
   logic [NSRC-1:0]      s_axis_tready;
   logic [NSRC-1:0]      s_axis_tlast  = '0;
   logic [NSRC-1:0]      s_axis_tuser  = '0;
   logic [DW-1:0]        m_axis_tdata;
   logic                 m_axis_tvalid;
   logic                 m_axis_tready = 1'b1;
   logic                 m_axis_tlast;
   logic                 m_axis_tuser;
   logic [1:0]           grant_idx;
   logic                 busy;
   logic [CW-1:0]        frame_cnt;
   logic                 trunc_err;

   always #5 aclk = ~aclk;

   axis_frame_arbiter #(
      .NUM_SRC   (NSRC),
      .DATA_W    (DW),
      .MAX_BEATS (MAXB),
      .CNT_W     (CW)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .grant_idx     (grant_idx),
      .busy          (busy),
      .frame_cnt     (frame_cnt),
      .trunc_err     (trunc_err)
   );

   int      n_vec  = 0;
   int      n_miss = 0;
   beat_t   src_q [NSRC][$];
   exp_t    sb_q [$];
   logic [NSRC-1:0] hs = '0;
   logic    bp_mode   = 1'b0;
   int      acc_beats = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit pending();
      for (int i = 0; i < NSRC; i++) if (src_q[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   // Queue one source frame and the output beats it must produce, including watchdog cuts.
   task automatic send_frame(input int src, input int n, input logic [DW-1:0] base, input logic user);
      int cnt = 0;
      for (int k = 0; k < n; k++) begin
         beat_t b;
         exp_t  e;
         b.data = base + DW'(k);
         b.last = (k == n - 1);
         b.user = user;
         src_q[src].push_back(b);
         e.data = b.data;
         e.last = b.last | (cnt == MAXB - 1);
         e.user = user;
         e.src  = 2'(src);
         sb_q.push_back(e);
         cnt = e.last ? 0 : cnt + 1;
      end
   endtask

   task automatic clear_queues();
      for (int i = 0; i < NSRC; i++) src_q[i].delete();
      sb_q.delete();
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((sb_q.size() > 0 || pending()) && n < budget) begin
         @(negedge aclk);
         n++;
      end
      check("drain_in_budget", 64'(n < budget), 1);
      if (n >= budget) clear_queues();
      @(posedge aclk); #2;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      clear_queues();
      repeat (2) @(posedge aclk);
      #2 aresetn = 1'b1;
      @(posedge aclk); #2;
   endtask

   // Handshakes are sampled mid-cycle and consumed by the driver after the next edge.
   always @(negedge aclk) hs = s_axis_tvalid & s_axis_tready;

   always begin
      @(posedge aclk); #1;
      for (int i = 0; i < NSRC; i++) begin
         if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         if (src_q[i].size() > 0) begin
            s_axis_tvalid[i]          = 1'b1;
            s_axis_tdata[i*DW +: DW]  = src_q[i][0].data;
            s_axis_tlast[i]           = src_q[i][0].last;
            s_axis_tuser[i]           = src_q[i][0].user;
         end else begin
            s_axis_tvalid[i] = 1'b0;
            s_axis_tlast[i]  = 1'b0;
            s_axis_tuser[i]  = 1'b0;
         end
      end
      m_axis_tready = bp_mode ? ~m_axis_tready : 1'b1;
   end

   logic          bubble_q = 1'b0;
   logic          rearb_q  = 1'b0;
   logic          stall_q  = 1'b0;
   logic [DW-1:0] stall_data = '0;

   always @(negedge aclk) begin
      logic [NSRC-1:0] exp_rdy;
      logic            next_bubble;
      exp_t            e;
      if (!aresetn) begin
         bubble_q = 1'b0;
         rearb_q  = 1'b0;
         stall_q  = 1'b0;
      end else begin
         if (rearb_q) check("rearb_after_bubble", m_axis_tvalid, 1);
         rearb_q = 1'b0;
         if (bubble_q) begin
            check("bubble_valid", m_axis_tvalid, 0);
            check("bubble_busy", busy, 0);
            rearb_q = |s_axis_tvalid;
         end
         if (!busy) begin
            check("idle_valid", m_axis_tvalid, 0);
            check("idle_ready", s_axis_tready, 0);
         end else if (sb_q.size() > 0) begin
            exp_rdy = '0;
            exp_rdy[sb_q[0].src] = m_axis_tready;
            check("grant_idx", grant_idx, sb_q[0].src);
            check("s_ready_mirror", s_axis_tready, exp_rdy);
         end
         if (stall_q && m_axis_tvalid) check("stall_hold", m_axis_tdata, stall_data);
         stall_q    = m_axis_tvalid && !m_axis_tready;
         stall_data = m_axis_tdata;
         next_bubble = 1'b0;
         if (m_axis_tvalid && m_axis_tready) begin
            acc_beats++;
            if (sb_q.size() == 0) begin
               check("unexpected_beat", m_axis_tdata, 0);
            end else begin
               e = sb_q.pop_front();
               check("beat_data", m_axis_tdata, e.data);
               check("beat_last", m_axis_tlast, e.last);
               check("beat_user", m_axis_tuser, e.user);
            end
            next_bubble = m_axis_tlast;
         end
         bubble_q = next_bubble;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      repeat (3) @(posedge aclk);
      #2;
      check("rst_valid", m_axis_tvalid, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_trunc", trunc_err, 0);
      check("rst_grant", grant_idx, 0);
      check("rst_ready", s_axis_tready, 0);
      aresetn = 1'b1;
      @(posedge aclk); #2;

      // Single 4-beat frame; tlast coincides with the watchdog limit and is not an error.
      send_frame(0, 4, 32'h10, 1'b0);
      for (int c = 0; c < 10 && !s_axis_tvalid[0]; c++) begin
         @(posedge aclk); #2;
      end
      check("t1_src_valid", s_axis_tvalid[0], 1);
      @(negedge aclk);
      check("t1_latency_idle", m_axis_tvalid, 0);
      @(negedge aclk);
      check("t1_latency_first", m_axis_tvalid, 1);
      wait_drain(100);
      check("t1_frame_cnt", frame_cnt, 1);
      check("t1_grant", grant_idx, 0);
      check("t1_trunc", trunc_err, 0);

      // All sources request 2-beat frames: grants 0,1,2,3,0 from a fresh pointer.
      do_reset();
      send_frame(0, 2, 32'h100, 1'b0);
      send_frame(1, 2, 32'h200, 1'b1);
      send_frame(2, 2, 32'h300, 1'b0);
      send_frame(3, 2, 32'h400, 1'b1);
      send_frame(0, 2, 32'h500, 1'b0);
      wait_drain(200);
      check("t2_frame_cnt", frame_cnt, 5);
      check("t2_last_grant", grant_idx, 0);

      // Backpressure on a 3-beat frame from source 2.
      base    = acc_beats;
      bp_mode = 1'b1;
      send_frame(2, 3, 32'h30, 1'b1);
      wait_drain(200);
      bp_mode = 1'b0;
      check("t3_beats", acc_beats - base, 3);
      check("t3_frame_cnt", frame_cnt, 6);

      // Watchdog truncation: 6-beat frame becomes a 4-beat and a 2-beat frame.
      check("t4_trunc_before", trunc_err, 0);
      base = acc_beats;
      send_frame(1, 6, 32'h60, 1'b0);
      wait_drain(200);
      check("t4_beats", acc_beats - base, 6);
      check("t4_trunc", trunc_err, 1);
      check("t4_frame_cnt", frame_cnt, 8);

      // Reset after 2 of 5 beats, then source 0 must win over source 2.
      base = acc_beats;
      send_frame(2, 5, 32'h70, 1'b0);
      for (int c = 0; c < 50 && (acc_beats - base) < 2; c++) @(negedge aclk);
      check("t5_two_beats", acc_beats - base, 2);
      @(posedge aclk); #2;
      aresetn = 1'b0;
      clear_queues();
      #1;
      check("t5_rst_valid", m_axis_tvalid, 0);
      check("t5_rst_last", m_axis_tlast, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_frame_cnt", frame_cnt, 0);
      check("t5_rst_trunc", trunc_err, 0);
      repeat (2) @(posedge aclk);
      #2 aresetn = 1'b1;
      @(posedge aclk); #2;
      send_frame(0, 1, 32'hA0, 1'b1);
      send_frame(2, 1, 32'hB0, 1'b0);
      wait_drain(100);
      check("t5_frame_cnt", frame_cnt, 2);

      // 17 single-beat frames rotating over all sources wrap the 4-bit counter to 1.
      do_reset();
      for (int k = 0; k < 17; k++) send_frame(k % NSRC, 1, 32'hC00 + DW'(k), k[0]);
      wait_drain(300);
      check("t6_frame_cnt_wrap", frame_cnt, 1);
      check("t6_trunc", trunc_err, 0);
      check("t6_last_grant", grant_idx, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
Frame-atomic round-robin arbiter that shares one AXI4-Stream master port among NUM_SRC source streams. The block sits upstream of the stream VIP/sink and in front of the axistream_master-style data path in test benches and RTL. A grant is held from the first beat to the tlast beat, so frames are never interleaved. An optional beat-count watchdog force-terminates runaway frames.

Parameters:
NUM_SRC, 4, number of source streams (2..8)
DATA_W, 32, tdata width in bits
MAX_BEATS, 256, beat limit per frame; 0 disables the watchdog
CNT_W, 16, width of the frame counter

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  NUM_SRC*DATA_W  source data; source i occupies bits [i*DATA_W +: DATA_W]
s_axis_tvalid  in  NUM_SRC  per-source valid
s_axis_tready  out  NUM_SRC  per-source ready
s_axis_tlast  in  NUM_SRC  per-source end of frame
s_axis_tuser  in  NUM_SRC  per-source user bit
m_axis_tdata  out  DATA_W  output data
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output end of frame
m_axis_tuser  out  1  output user bit
grant_idx  out  $clog2(NUM_SRC)  index of the current or last granted source
busy  out  1  a frame is in progress
frame_cnt  out  CNT_W  count of completed output frames; wraps
trunc_err  out  1  sticky; set when the watchdog truncates a frame

Behaviour:
- Reset: asynchronous on aresetn low. Applies immediately, including mid-frame. All outputs go to 0, state goes to IDLE, the round-robin pointer is set to NUM_SRC-1 so source 0 has priority first. Any partial frame is abandoned and no tlast is generated.
- States: IDLE and BUSY.
- IDLE:
  - m_axis_tvalid = 0 and all s_axis_tready = 0.
  - If any s_axis_tvalid is high, pick the first valid source searching upward from ptr+1 modulo NUM_SRC.
  - Register that source as grant_idx, set ptr to it, clear the beat counter, and move to BUSY on the next edge.
  - Arbitration latency is 1 cycle from a valid request to the first m_axis_tvalid.
- BUSY (g = grant_idx):
  - Combinational pass-through: m_axis_tdata/tvalid/tuser come from source g.
  - m_axis_tlast = s_axis_tlast[g] OR wd_hit.
  - s_axis_tready[g] = m_axis_tready. All other readys are 0.
  - A beat is accepted when m_axis_tvalid and m_axis_tready are both high. Each accepted beat increments the beat counter.
  - wd_hit = (MAX_BEATS != 0) AND (beat counter == MAX_BEATS-1).
  - On an accepted beat with m_axis_tlast high: frame_cnt increments (wrap at 2^CNT_W), and state returns to IDLE. There is a mandatory 1-cycle bubble between frames.
  - If that tlast came only from wd_hit, trunc_err is set. It stays set until reset. The remainder of the source frame is then arbitrated as a new frame.
- Source changes that arrive while a beat is stalled are not policed. AXIS rules are the sources' responsibility.
- Requests on non-granted sources never affect the current frame.
- busy = (state == BUSY).
- Fairness: with all sources continuously requesting, grants rotate 0,1,2,...,NUM_SRC-1,0. No source waits more than NUM_SRC-1 frames.
- Simultaneous events:
  - tlast beat and a new request in the same cycle: the request is served after the IDLE cycle, using the updated ptr.
  - tlast and wd_hit on the same beat: counted as a normal frame end; trunc_err is not set.
- Single-beat frames (tlast on the first beat) are legal and cost 2 cycles per frame.

Decomposition:
- Package axis_arb_pkg holds:
  - the state enum typedef (IDLE, BUSY);
  - the default-width localparams;
  - a function rr_pick(req, ptr) that returns the next index.
- Sub-module rr_pointer_arbiter holds the combinational round-robin pick from a request vector and pointer, plus the registered pointer update on a load strobe. The top level holds the FSM, mux, counters and flags.

Test Plan:
- Single source: source 0 sends a 4-beat frame 0x10..0x13 with tready always 1 -> m_axis_tvalid first high 1 cycle after s_axis_tvalid[0]; 4 output beats in order; tlast on 0x13; frame_cnt = 1; grant_idx = 0.
- All 4 sources request 2-beat frames continuously -> grant order 0,1,2,3,0; no interleaving; 1 idle cycle between frames; frame_cnt = 5 after 5 frames.
- Backpressure: m_axis_tready toggles 1,0,1,0 during a 3-beat frame from source 2 -> s_axis_tready[2] mirrors m_axis_tready; all other readys stay 0; data held stable; exactly 3 beats transferred.
- Watchdog: MAX_BEATS = 4, source 1 sends 6 beats with tlast on beat 6 -> output tlast on beat 4; trunc_err = 1; beats 5-6 emerge as a second frame; frame_cnt = 2.
- Reset mid-frame: aresetn low after 2 of 5 beats -> m_axis_tvalid, busy, frame_cnt and trunc_err all 0 immediately. After release, source 0 wins first.
- Counter wrap: CNT_W = 4, 17 single-beat frames -> frame_cnt = 1.
